// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Primary opcodes reserved for a later predecode step.
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t word_align(word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: redirect input, instruction-memory port and datapath handshake.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic  redirect;
  word_t redirect_pc;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;

  logic  out_valid;
  logic  out_ready;
  word_t out_instr;
  word_t out_pc;

  // master is the fetch stage; slave is the memory plus datapath around it.
  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr}; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CntW-1:0]  count
);

  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign do_push = push && ((count_q != Full) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem read, buffered {pc, instr} queue,
// valid/ready output and a redirect that flushes everything in flight.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     QDEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  localparam int unsigned     CntW      = $clog2(QDEPTH) + 1;
  localparam logic [CntW:0]   QDepthOcc = (CntW + 1)'(QDEPTH);

  word_t           fetch_pc_q, fetch_pc_d;
  word_t           tag_pc_q, tag_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            stale_q, stale_d;

  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  logic            resp;
  logic            pending;
  logic            outstanding_eff;
  logic            req;
  logic            grant;
  logic            push;
  logic            pop;
  logic            out_valid;

  assign resp            = bus.imem_rvalid && outstanding_q;
  assign pending         = resp && !stale_q;
  assign outstanding_eff = outstanding_q && !bus.imem_rvalid;

  // Reserve a slot for a response landing this cycle before issuing another read.
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, pending};
  assign req       = reset && !outstanding_eff && (occupancy < QDepthOcc);
  assign grant     = req && bus.imem_gnt;

  assign out_valid = (count != '0);
  assign push      = pending && !bus.redirect;
  assign pop       = out_valid && bus.out_ready && !bus.redirect;

  assign push_entry = '{pc: tag_pc_q, instr: bus.imem_rdata};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    tag_pc_d      = tag_pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;

    if (resp) begin
      outstanding_d = 1'b0;
      stale_d       = 1'b0;
    end

    if (grant) begin
      outstanding_d = 1'b1;
      tag_pc_d      = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + word_t'(INSTR_BYTES);
    end

    // Any read still owed by memory after this edge belongs to the old path.
    if (bus.redirect) begin
      fetch_pc_d = word_align(bus.redirect_pc);
      if (outstanding_eff || grant) begin
        stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= word_align(RESET_PC);
      tag_pc_q      <= '0;
      outstanding_q <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      tag_pc_q      <= tag_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? head.instr : '0;
  assign bus.out_pc    = out_valid ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a queue-based reference model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int unsigned QD  = 4;
  localparam word_t       RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(
    .QDEPTH   (QD),
    .RESET_PC (RPC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int gnt_pct;
  int lat_min;
  int lat_max;
  int spur_pct;
  bit chk_en;

  // Memory: at most one read in service, answered after a random latency.
  bit    mem_busy;
  int    mem_cnt;
  word_t mem_addr;

  // Reference model state.
  word_t        m_pc;
  word_t        m_tag;
  bit           m_out;
  bit           m_stale;
  fetch_entry_t m_q[$];

  logic  s_req;
  logic  s_valid;
  word_t s_addr;
  word_t s_pc;
  word_t s_instr;

  function automatic word_t mem_word(word_t a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input word_t obs, input word_t exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst_n, input bit redir, input word_t rpc, input bit ready);
    bit    rv;
    bit    gnt;
    bit    resp;
    bit    push;
    bit    req;
    bit    valid;
    bit    grant;
    bit    pop;
    word_t rdata;

    @(negedge clk);
    rv    = 1'b0;
    rdata = $urandom;
    if (mem_busy && mem_cnt == 0) begin
      rv    = 1'b1;
      rdata = mem_word(mem_addr);
    end else if (!mem_busy && !m_out && ($urandom_range(99) < spur_pct)) begin
      rv = 1'b1;
    end
    gnt = ($urandom_range(99) < gnt_pct);

    reset            = rst_n;
    bus.redirect     = redir;
    bus.redirect_pc  = rpc;
    bus.out_ready    = ready;
    bus.imem_gnt     = gnt;
    bus.imem_rvalid  = rv;
    bus.imem_rdata   = rdata;

    resp  = rv && m_out;
    push  = resp && !m_stale;
    req   = rst_n && !(m_out && !rv) && ((m_q.size() + int'(push)) < QD);
    valid = (m_q.size() != 0);

    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.out_valid;
    s_pc    = bus.out_pc;
    s_instr = bus.out_instr;

    if (chk_en) begin
      check("imem_req", 32'(s_req), 32'(req));
      if (req) check("imem_addr", s_addr, m_pc);
      check("out_valid", 32'(s_valid), 32'(valid));
      if (valid) begin
        check("out_pc", s_pc, m_q[0].pc);
        check("out_instr", s_instr, m_q[0].instr);
      end
    end

    grant = req && gnt;
    pop   = valid && ready;
    if (chk_en && pop && rst_n && !redir) check("consumed_instr", s_instr, mem_word(s_pc));

    if (!rst_n) begin
      m_q.delete();
      m_pc    = RPC;
      m_tag   = '0;
      m_out   = 1'b0;
      m_stale = 1'b0;
    end else if (redir) begin
      m_q.delete();
      m_stale = (m_out && !rv) || grant;
      m_out   = grant || (m_out && !rv);
      if (grant) m_tag = m_pc;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back('{pc: m_tag, instr: rdata});
      if (resp) begin
        m_out   = 1'b0;
        m_stale = 1'b0;
      end
      if (grant) begin
        m_out = 1'b1;
        m_tag = m_pc;
        m_pc  = m_pc + 32'd4;
      end
    end

    if (!rst_n) begin
      mem_busy = 1'b0;
    end else begin
      if (mem_busy) begin
        if (mem_cnt == 0) mem_busy = 1'b0;
        else mem_cnt--;
      end
      if (s_req && gnt) begin
        mem_busy = 1'b1;
        mem_cnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
        mem_addr = s_addr;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t prev_pc;
    bool_loop: begin end
    gnt_pct  = 100;
    lat_min  = 1;
    lat_max  = 1;
    spur_pct = 0;
    chk_en   = 1'b0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    mem_addr = '0;
    m_pc     = RPC;
    m_tag    = '0;
    m_out    = 1'b0;
    m_stale  = 1'b0;
    reset            = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.out_ready    = 1'b0;
    bus.imem_gnt     = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;

    // Reset state.
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("rst_req", 32'(s_req), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_pc", s_pc, 32'd0);
    check("rst_instr", s_instr, 32'd0);

    // Release with single-cycle memory: grant, rvalid, then first instruction.
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("first_req", 32'(s_req), 32'd1);
    check("first_addr", s_addr, RPC);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("second_addr", s_addr, RPC + 32'd4);
    check("no_bypass", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("first_out_valid", 32'(s_valid), 32'd1);
    check("first_out_pc", s_pc, RPC);
    prev_pc = s_pc;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      check("stream_gap", 32'(s_valid), 32'd1);
      check("stream_pc", s_pc, prev_pc + 32'd4);
      prev_pc = s_pc;
    end

    // Backpressure fills the queue and stalls fetch.
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    check("full_req", 32'(s_req), 32'd0);
    check("full_valid", 32'(s_valid), 32'd1);
    for (int k = 0; k < int'(QD); k++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      check("drain_valid", 32'(s_valid), 32'd1);
      check("drain_pc", s_pc, RPC + 32'(4 * k));
    end

    // Redirect while a slow response is outstanding.
    lat_min = 3;
    lat_max = 3;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    check("redir_out_req", 32'(s_req), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      if (s_req) break;
    end
    check("redir_req_seen", 32'(s_req), 32'd1);
    check("redir_addr", s_addr, 32'h0000_0100);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      if (s_valid) break;
    end
    check("redir_valid_seen", 32'(s_valid), 32'd1);
    check("redir_out_pc", s_pc, 32'h0000_0100);

    // Redirect coinciding with rvalid and a pop.
    lat_min = 1;
    lat_max = 1;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_2000, 1'b1);
    check("rvp_pop_present", 32'(s_valid), 32'd1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("rvp_empty", 32'(s_valid), 32'd0);
    check("rvp_req", 32'(s_req), 32'd1);
    check("rvp_addr", s_addr, 32'h0000_2000);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      if (s_valid) break;
    end
    check("rvp_out_pc", s_pc, 32'h0000_2000);

    // Stalled grant near the top of the address space, then wrap.
    gnt_pct = 0;
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      if (s_req) break;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      check("stall_req", 32'(s_req), 32'd1);
      check("stall_addr", s_addr, 32'hFFFF_FFFC);
    end
    gnt_pct = 100;
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("wrap_grant_addr", s_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("wrap_addr", s_addr, 32'h0000_0000);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("wrap_pc_hi", s_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("wrap_pc_lo", s_pc, 32'h0000_0000);

    // Reset with two entries queued and a read outstanding.
    lat_min = 3;
    lat_max = 3;
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      if (m_q.size() == 2 && m_out) break;
    end
    check("pre_rst_valid", 32'(s_valid), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("mid_rst_req", 32'(s_req), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("post_rst_valid", 32'(s_valid), 32'd0);
    check("post_rst_req", 32'(s_req), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("post_rst_req_up", 32'(s_req), 32'd1);
    check("post_rst_addr", s_addr, RPC);

    // Randomized traffic against the model.
    gnt_pct  = 60;
    lat_min  = 1;
    lat_max  = 3;
    spur_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      bit    r_rst;
      bit    r_redir;
      bit    r_ready;
      word_t r_pc;
      if (i == 1500) begin
        gnt_pct = 100;
        lat_max = 1;
      end
      r_rst   = !($urandom_range(199) == 0);
      r_redir = ($urandom_range(99) < 4);
      r_ready = ($urandom_range(99) < 70);
      r_pc    = $urandom_range(1) ? word_t'($urandom) : (32'hFFFF_FFF0 + word_t'($urandom_range(15)));
      cycle(r_rst, r_redir, r_pc, r_ready);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
